// File: rtl/axi_burst_sched.sv
// Round-robin burst scheduler: grants one requester at a time, latches its
// burst command and sequences per-beat addresses (FIXED / INCR / WRAP).
// Ports:
//   clk, rstn                   clock, async active-low reset
//   req_valid/req_ready         per-requester command handshake (req_ready is combinational)
//   req_addr/burst/size/len/prot/write  packed per-requester command fields
//   grant                       one-hot owner of the current burst
//   addr/burst/size/prot/write  current beat address and latched attributes
//   beat_valid/beat_ready       beat handshake with the slave
//   beat_last                   current beat is the final beat
//   busy                        a burst is in progress
module axi_burst_sched #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]          req_burst,
  input  logic [NUM_REQ*3-1:0]          req_size,
  input  logic [NUM_REQ*8-1:0]          req_len,
  input  logic [NUM_REQ*4-1:0]          req_prot,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [2:0]                    burst,
  output logic [2:0]                    size,
  output logic [3:0]                    prot,
  output logic                          write,
  output logic                          beat_valid,
  input  logic                          beat_ready,
  output logic                          beat_last,
  output logic                          busy
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic              fixed_q;
  logic              wrap_q;
  logic [2:0]        wrap_sh_q;

  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic              hs;
  logic              done;

  // Requester index base+off taken modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned t;
    t = 32'(base) + off;
    if (t >= NUM_REQ) t = t - NUM_REQ;
    return IDX_W'(t);
  endfunction

  // First valid requester starting at rr_ptr.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[wrap_idx(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign beat_valid = (state_q == BURST);
  assign busy       = (state_q == BURST);
  assign beat_last  = (state_q == BURST) && (cnt_q == len_q);

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    hs        = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready = NUM_REQ'(1) << win_idx;
          hs        = 1'b1;
          state_d   = BURST;
        end
      end
      BURST: begin
        if (beat_ready && beat_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Keep the accept strobe quiet while reset is asserted.
    if (!rstn) req_ready = '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Winner's command fields, size clamped and WRAP length decoded.
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [2:0]            sel_burst;
  logic [2:0]            sel_size_raw;
  logic [2:0]            sel_size;
  logic [7:0]            sel_len;
  logic                  sel_wrap_ok;
  logic [2:0]            sel_wrap_sh;

  always_comb begin
    sel_addr     = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_burst    = req_burst[win_idx*3 +: 3];
    sel_size_raw = req_size[win_idx*3 +: 3];
    sel_len      = req_len[win_idx*8 +: 8];
    sel_size     = (sel_size_raw > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : sel_size_raw;
    sel_wrap_ok  = 1'b1;
    sel_wrap_sh  = 3'd0;
    case (sel_len)
      8'd1:    sel_wrap_sh = 3'd1;
      8'd3:    sel_wrap_sh = 3'd2;
      8'd7:    sel_wrap_sh = 3'd3;
      8'd15:   sel_wrap_sh = 3'd4;
      default: sel_wrap_ok = 1'b0;
    endcase
  end

  // Next beat address; WRAP with an illegal length falls back to INCR.
  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] addr_incr;
  logic [ADDR_WIDTH-1:0] addr_wrap;
  logic [ADDR_WIDTH-1:0] addr_next;

  always_comb begin
    beat_bytes = ADDR_WIDTH'(1) << size;
    wrap_bytes = beat_bytes << wrap_sh_q;
    addr_incr  = (addr & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;
    addr_wrap  = (addr & ~(wrap_bytes - ADDR_WIDTH'(1))) |
                 ((addr + beat_bytes) & (wrap_bytes - ADDR_WIDTH'(1)));
    if (fixed_q)     addr_next = addr;
    else if (wrap_q) addr_next = addr_wrap;
    else             addr_next = addr_incr;
  end

  // Command latch, beat sequencing and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr    <= '0;
      win_q     <= '0;
      grant     <= '0;
      addr      <= '0;
      burst     <= '0;
      size      <= '0;
      prot      <= '0;
      write     <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      fixed_q   <= 1'b0;
      wrap_q    <= 1'b0;
      wrap_sh_q <= '0;
    end else if (hs) begin
      win_q     <= win_idx;
      grant     <= NUM_REQ'(1) << win_idx;
      addr      <= sel_addr;
      burst     <= sel_burst;
      size      <= sel_size;
      prot      <= req_prot[win_idx*4 +: 4];
      write     <= req_write[win_idx];
      len_q     <= sel_len;
      cnt_q     <= '0;
      fixed_q   <= (sel_burst == 3'd0);
      wrap_q    <= (sel_burst == 3'd2) && sel_wrap_ok;
      wrap_sh_q <= sel_wrap_sh;
    end else if (state_q == BURST && beat_ready) begin
      cnt_q <= cnt_q + 8'd1;
      addr  <= addr_next;
      if (done) begin
        grant  <= '0;
        rr_ptr <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_sched.sv
// Bench for axi_burst_sched: directed scenarios plus randomized bursts checked
// against an arithmetic reference of beat addresses and round-robin order.
module tb_axi_burst_sched;

  localparam int unsigned NR = 2;

  logic          clk;
  logic          rstn;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*32-1:0] req_addr;
  logic [NR*3-1:0]  req_burst;
  logic [NR*3-1:0]  req_size;
  logic [NR*8-1:0]  req_len;
  logic [NR*4-1:0]  req_prot;
  logic [NR-1:0]    req_write;
  logic [NR-1:0] grant;
  logic [31:0]   addr;
  logic [2:0]    burst;
  logic [2:0]    size;
  logic [3:0]    prot;
  logic          write;
  logic          beat_valid;
  logic          beat_ready;
  logic          beat_last;
  logic          busy;

  axi_burst_sched #(.NUM_REQ(NR), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_burst(req_burst), .req_size(req_size),
    .req_len(req_len), .req_prot(req_prot), .req_write(req_write),
    .grant(grant), .addr(addr), .burst(burst), .size(size), .prot(prot),
    .write(write), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_last(beat_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rr_m  = 0;

  logic [31:0] c_addr  [NR];
  logic [2:0]  c_burst [NR];
  logic [2:0]  c_size  [NR];
  logic [7:0]  c_len   [NR];
  logic [3:0]  c_prot  [NR];
  logic        c_write [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address of beat k from the burst rules, computed from the start address.
  function automatic logic [31:0] exp_addr(input logic [31:0] start, input logic [2:0] bt,
                                           input logic [2:0] sz, input logic [7:0] ln,
                                           input int k);
    longint s, b, n, c, st;
    s  = (sz > 3'd2) ? 2 : longint'(sz);
    b  = longint'(1) << s;
    n  = longint'(ln) + 1;
    st = longint'(start);
    if (bt == 3'd0) return start;
    if (bt == 3'd2 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
      c = b * n;
      return 32'((st - st % c) + ((st % c + longint'(k) * b) % c));
    end
    if (k == 0) return start;
    return 32'((st - st % b) + longint'(k) * b);
  endfunction

  task automatic set_cmd(input int i, input logic [31:0] a, input logic [2:0] bt,
                         input logic [2:0] sz, input logic [7:0] ln,
                         input logic [3:0] pr, input logic wr);
    c_addr[i] = a; c_burst[i] = bt; c_size[i] = sz;
    c_len[i] = ln; c_prot[i] = pr; c_write[i] = wr;
    req_addr[i*32 +: 32] = a;
    req_burst[i*3 +: 3]  = bt;
    req_size[i*3 +: 3]   = sz;
    req_len[i*8 +: 8]    = ln;
    req_prot[i*4 +: 4]   = pr;
    req_write[i]         = wr;
    req_valid[i]         = 1'b1;
  endtask

  // Check the accept strobe against the round-robin model, then take the edge.
  task automatic handshake(output int w);
    logic [NR-1:0] oh;
    w = -1;
    for (int k = 0; k < int'(NR); k++)
      if (w < 0 && req_valid[(rr_m + k) % int'(NR)]) w = (rr_m + k) % int'(NR);
    if (w < 0) w = 0;
    oh = NR'(1) << w;
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("req_ready", 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
  endtask

  // Collect all beats of requester w's burst and compare against the model.
  task automatic run_burst(input int w, input bit rnd, input logic [31:0] pat);
    int k = 0;
    int cyc = 0;
    logic [NR-1:0] oh;
    logic [2:0] sz;
    oh = NR'(1) << w;
    sz = (c_size[w] > 3'd2) ? 3'd2 : c_size[w];
    while (k <= int'(c_len[w]) && cyc < 400) begin
      beat_ready = rnd ? ($urandom_range(0, 3) != 0) : ((cyc < 32) ? pat[cyc] : 1'b1);
      #1;
      chk("beat_valid", 64'(beat_valid), 64'd1);
      chk("addr", 64'(addr), 64'(exp_addr(c_addr[w], c_burst[w], c_size[w], c_len[w], k)));
      chk("beat_last", 64'(beat_last), 64'(k == int'(c_len[w])));
      chk("grant", 64'(grant), 64'(oh));
      chk("attrs", {49'd0, burst, sz == size, prot, write, req_ready},
                   {49'd0, c_burst[w], 1'b1, c_prot[w], c_write[w], {NR{1'b0}}});
      if (beat_ready) k++;
      cyc++;
      @(posedge clk); #1;
    end
    if (k <= int'(c_len[w])) chk("burst_timeout", 64'd0, 64'd1);
    beat_ready = 1'b0;
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_grant", 64'(grant), 64'd0);
    rr_m = (w + 1) % int'(NR);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    rr_m = 0;
  endtask

  int w;
  int ln_sel;
  logic [7:0] ln;
  logic [NR-1:0] mask;

  initial begin
    rstn = 1'b0; beat_ready = 1'b0;
    req_valid = '0; req_addr = '0; req_burst = '0; req_size = '0;
    req_len = '0; req_prot = '0; req_write = '0;
    @(posedge clk); #1;
    req_valid = '1;
    @(posedge clk); #1;
    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_outs", {16'd0, grant, addr, burst, size, prot, write, beat_valid, beat_last, busy},
                    64'd0);
    req_valid = '0;
    rstn = 1'b1;
    @(posedge clk); #1;

    // INCR
    set_cmd(0, 32'h1000, 3'd1, 3'd2, 8'd3, 4'h5, 1'b1);
    handshake(w); run_burst(w, 1'b0, 32'hFFFF_FFFF);
    // WRAP
    set_cmd(0, 32'h1008, 3'd2, 3'd2, 8'd3, 4'h2, 1'b0);
    handshake(w); run_burst(w, 1'b0, 32'hFFFF_FFFF);
    // FIXED and INCR from an unaligned start
    set_cmd(1, 32'h2003, 3'd0, 3'd0, 8'd2, 4'h1, 1'b0);
    handshake(w); run_burst(w, 1'b0, 32'hFFFF_FFFF);
    set_cmd(1, 32'h2003, 3'd1, 3'd0, 8'd2, 4'h1, 1'b1);
    handshake(w); run_burst(w, 1'b0, 32'hFFFF_FFFF);
    // Backpressure: second beat held three cycles
    set_cmd(0, 32'h1000, 3'd1, 3'd2, 8'd3, 4'h0, 1'b0);
    handshake(w); run_burst(w, 1'b0, 32'hFFFF_FFF1);
    // Illegal WRAP length runs as INCR; oversize clamps
    set_cmd(1, 32'h0000_1FFA, 3'd2, 3'd7, 8'd2, 4'hF, 1'b1);
    handshake(w); run_burst(w, 1'b0, 32'hFFFF_FFFF);

    // Arbitration from reset
    do_reset();
    set_cmd(0, 32'h100, 3'd1, 3'd2, 8'd0, 4'h3, 1'b0);
    set_cmd(1, 32'h200, 3'd1, 3'd2, 8'd0, 4'h4, 1'b1);
    handshake(w); chk("arb_first", 64'(w), 64'd0); run_burst(w, 1'b0, 32'hFFFF_FFFF);
    handshake(w); chk("arb_second", 64'(w), 64'd1); run_burst(w, 1'b0, 32'hFFFF_FFFF);
    req_valid = '1;
    handshake(w); chk("arb_again", 64'(w), 64'd0); run_burst(w, 1'b0, 32'hFFFF_FFFF);
    handshake(w); run_burst(w, 1'b0, 32'hFFFF_FFFF);

    // Reset during the third beat
    set_cmd(0, 32'h1000, 3'd1, 3'd2, 8'd3, 4'h6, 1'b1);
    handshake(w);
    beat_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_addr", 64'(addr), 64'h1008);
    rstn = 1'b0;
    #1;
    chk("mid_rst", {31'd0, addr, grant, beat_valid, busy}, 64'd0);
    beat_ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; rr_m = 0;
    set_cmd(1, 32'h3000, 3'd1, 3'd2, 8'd1, 4'h7, 1'b0);
    handshake(w); chk("post_rst_win", 64'(w), 64'd1); run_burst(w, 1'b0, 32'hFFFF_FFFF);

    // Randomized bursts with random slave pacing
    for (int r = 0; r < 60; r++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      req_valid = '0;
      for (int i = 0; i < int'(NR); i++) begin
        if (mask[i]) begin
          ln_sel = int'($urandom_range(0, 5));
          case (ln_sel)
            0: ln = 8'd0;
            1: ln = 8'd1;
            2: ln = 8'd3;
            3: ln = 8'd7;
            4: ln = 8'd15;
            default: ln = 8'($urandom_range(0, 20));
          endcase
          set_cmd(i, $urandom, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), ln,
                  4'($urandom), 1'($urandom));
        end
      end
      handshake(w);
      run_burst(w, 1'b1, 32'd0);
    end
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
